clk_div_sched: RTL and testbench



---
 rtl/clk_sched_pkg.sv | 14 +
 rtl/clk_sched_chan.sv | 96 +++++++++
 rtl/clk_div_sched.sv | 86 ++++++++
 tb/tb_clk_div_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared state encoding and constants for the clock divider scheduler
package clk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  localparam int CW_DEFAULT = 16;
  localparam int DIV_MIN    = 1;

endpackage

// File: rtl/clk_sched_chan.sv
// rtl/clk_sched_chan.sv - one divided clock channel: phase delay, half-period counter, drain freeze
// CLK_SCHED_TICK_EN: when defined, tick pulses in the cycle clk_out rises; otherwise tick is tied low.
module clk_sched_chan
  import clk_sched_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic          drain,
  input  logic [CW-1:0] div,
  input  logic [CW-1:0] phase,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0] pc_q, pc_n;
  logic [CW-1:0] hc_q, hc_n;
  logic          started_q, started_n;
  logic          clk_q, clk_n;

  always_comb begin
    pc_n      = pc_q;
    hc_n      = hc_q;
    started_n = started_q;
    clk_n     = clk_q;
    if (load) begin
      hc_n = div;
      if (phase == '0) begin
        clk_n     = 1'b1;
        started_n = 1'b1;
        pc_n      = '0;
      end else begin
        clk_n     = 1'b0;
        started_n = 1'b0;
        pc_n      = phase;
      end
    end else if (run) begin
      if (!started_q) begin
        if (pc_q == CW'(1)) begin
          clk_n     = 1'b1;
          started_n = 1'b1;
          hc_n      = div;
          pc_n      = '0;
        end else begin
          pc_n = pc_q - CW'(1);
        end
      end else if (hc_q == CW'(1)) begin
        clk_n = ~clk_q;
        hc_n  = div;
      end else begin
        hc_n = hc_q - CW'(1);
      end
    end else if (drain && clk_q) begin
      // a high channel completes its high half, then stays low for the rest of the drain
      if (hc_q == CW'(1)) begin
        clk_n = 1'b0;
        hc_n  = div;
      end else begin
        hc_n = hc_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      hc_q      <= CW'(DIV_MIN);
      started_q <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      pc_q      <= pc_n;
      hc_q      <= hc_n;
      started_q <= started_n;
      clk_q     <= clk_n;
    end
  end

  assign clk_out = clk_q;

`ifdef CLK_SCHED_TICK_EN
  logic tick_q;

  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= clk_n & ~clk_q;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - sequenced bank of phase-aligned divided clocks with glitch-free stop
// CLK_SCHED_TICK_EN: when defined, each channel drives a rising-edge tick pulse.
module clk_div_sched
  import clk_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = CW_DEFAULT,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [CW-1:0]  cfg_phase,
  output logic           cfg_ready,
  input  logic           start,
  input  logic           stop,
  output logic           busy,
  output logic           running,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  sched_state_e state_q, state_n;

  logic [CW-1:0] div_r   [NCH];
  logic [CW-1:0] phase_r [NCH];

  logic ch_load, ch_run, ch_drain;
  logic all_low;

  assign all_low = ~|clk_out;

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = ALIGN;
      ALIGN:   state_n = stop ? DRAIN : RUN;
      RUN:     if (stop) state_n = DRAIN;
      DRAIN:   if (all_low) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // channels react to stop in the same cycle it is sampled, so nothing new rises after it
  assign ch_load  = (state_q == ALIGN) && !stop;
  assign ch_run   = (state_q == RUN) && !stop;
  assign ch_drain = ((state_q == RUN || state_q == ALIGN) && stop) || (state_q == DRAIN);

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign running   = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        div_r[i]   <= CW'(DIV_MIN);
        phase_r[i] <= '0;
      end
    end else if (cfg_ready && cfg_we && (int'(cfg_ch) < NCH)) begin
      div_r[cfg_ch]   <= (cfg_div == '0) ? CW'(DIV_MIN) : cfg_div;
      phase_r[cfg_ch] <= cfg_phase;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_sched_chan #(.CW(CW)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load    (ch_load),
      .run     (ch_run),
      .drain   (ch_drain),
      .div     (div_r[g]),
      .phase   (phase_r[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - directed self-checking bench for clk_div_sched
module tb_clk_div_sched;

`ifdef CLK_SCHED_TICK_EN
  localparam bit TICK_EN = 1'b1;
`else
  localparam bit TICK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [15:0] cfg_phase;
  logic        cfg_ready;
  logic        start;
  logic        stop;
  logic        busy;
  logic        running;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int n_checks = 0;
  int n_fails  = 0;
  int dv [4];
  int ph [4];

  always #5 clk = ~clk;

  clk_div_sched #(.NCH(4), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .running   (running),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // channel is high at cycle t (start sampled at t=0) per the documented edge schedule
  function automatic bit exp_bit(int t, int p, int d);
    if (t < 2 + p) return 1'b0;
    return (((t - 2 - p) / d) % 2) == 0;
  endfunction

  function automatic logic [3:0] exp_vec(int t);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = exp_bit(t, ph[i], dv[i]);
    return v;
  endfunction

  task automatic cfg_write(input int ch, input int d, input int p);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 16'(d); cfg_phase = 16'(p);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic run_check(input int ncyc, input int wr_at);
    logic [3:0] e, ep;
    start = 1'b1;
    step();
    start = 1'b0;
    check("align_busy", 32'(busy), 1);
    check("align_running", 32'(running), 0);
    check("align_ready", 32'(cfg_ready), 0);
    check("align_clk", 32'(clk_out), 0);
    for (int t = 2; t <= ncyc; t++) begin
      if (t - 1 == wr_at) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd7; cfg_phase = 16'd0;
      end
      step();
      cfg_we = 1'b0;
      e  = exp_vec(t);
      ep = exp_vec(t - 1);
      check("run_clk", 32'(clk_out), 32'(e));
      check("run_tick", 32'(tick), TICK_EN ? 32'(e & ~ep) : 32'd0);
      check("run_running", 32'(running), 1);
    end
  endtask

  task automatic stop_and_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 0; k < 60 && busy; k++) step();
    check("drain_idle", 32'(busy), 0);
    check("drain_clk", 32'(clk_out), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin dv[i] = 1; ph[i] = 0; end
    step();
    step();
    rst = 1'b0;
    check("rst_clk", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_running", 32'(running), 0);
    check("rst_ready", 32'(cfg_ready), 1);

    // defaults: every channel div=1 phase=0
    run_check(8, -1);
    stop_and_idle();

    // mixed divides and phases
    cfg_write(0, 3, 0); dv[0] = 3; ph[0] = 0;
    cfg_write(1, 3, 3); dv[1] = 3; ph[1] = 3;
    cfg_write(2, 5, 1); dv[2] = 5; ph[2] = 1;
    run_check(26, -1);
    stop_and_idle();

    // stop while ch0 high with two cycles left, ch1/ch2 still in phase delay
    cfg_write(1, 3, 10); ph[1] = 10;
    cfg_write(2, 5, 10); ph[2] = 10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("stp_t2", 32'(clk_out), 32'h9);
    step();
    check("stp_t3", 32'(clk_out), 32'h1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stp_t4_clk", 32'(clk_out), 32'h1);
    check("stp_t4_run", 32'(running), 0);
    check("stp_t4_busy", 32'(busy), 1);
    check("stp_t4_tick", 32'(tick), 0);
    step();
    check("stp_t5_clk", 32'(clk_out), 0);
    check("stp_t5_busy", 32'(busy), 1);
    step();
    check("stp_t6_busy", 32'(busy), 0);
    check("stp_t6_ready", 32'(cfg_ready), 1);

    // config write while running is dropped
    run_check(14, 3);
    stop_and_idle();
    run_check(14, -1);
    stop_and_idle();

    // start and stop together, stop held through ALIGN
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0;
    check("ss_align_busy", 32'(busy), 1);
    check("ss_align_clk", 32'(clk_out), 0);
    step();
    stop = 1'b0;
    check("ss_drain_busy", 32'(busy), 1);
    check("ss_drain_run", 32'(running), 0);
    check("ss_drain_clk", 32'(clk_out), 0);
    step();
    check("ss_idle_busy", 32'(busy), 0);
    check("ss_idle_clk", 32'(clk_out), 0);

    // reset in the middle of RUN
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin dv[i] = 1; ph[i] = 0; end
    check("mrst_clk", 32'(clk_out), 0);
    check("mrst_tick", 32'(tick), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_ready", 32'(cfg_ready), 1);
    run_check(7, -1);
    stop_and_idle();

    // zero divide is stored as one
    cfg_write(2, 0, 2); dv[2] = 1; ph[2] = 2;
    run_check(10, -1);
    stop_and_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
